// File: rtl/eth_row_sender_pkg.sv
// Shared types for the Ethernet row sender: read FSM states, row descriptor, frame constants.
package eth_tx_pkg;

  typedef enum logic [2:0] {IDLE, START, LEAD, STREAM, DONE, GAP} rd_state_t;

  typedef struct packed {
    logic [14:0] len;
    logic [7:0]  row;
    logic        sof;
  } row_desc_t;

  localparam int PARAM_FRAME_BYTES = 64;

endpackage

// File: rtl/eth_row_sender_if.sv
// Pixel-in / TX-out bundle for eth_row_sender; parameter-frame signals exist only with ETH_ROW_PARAM_EN.
interface eth_row_sender_if;
  logic [7:0]  i_pix_data;
  logic        i_pix_valid;
  logic        i_pix_sof;
  logic        i_pix_eol;
  logic        i_eth_busy;
  logic [7:0]  o_raw_data;
  logic        o_raw_data_valid;
  logic [14:0] o_data_byte;
  logic [7:0]  o_row_number;
  logic        o_sof;
  logic        o_overflow;
  logic [15:0] o_drop_count;
`ifdef ETH_ROW_PARAM_EN
  logic        i_param_req;
  logic [7:0]  i_param_data;
  logic        o_param_rd;
  logic        o_param_flag;
`endif

  modport master (
`ifdef ETH_ROW_PARAM_EN
    output i_param_req, i_param_data,
    input  o_param_rd, o_param_flag,
`endif
    output i_pix_data, i_pix_valid, i_pix_sof, i_pix_eol, i_eth_busy,
    input  o_raw_data, o_raw_data_valid, o_data_byte, o_row_number, o_sof,
    input  o_overflow, o_drop_count
  );

  modport slave (
`ifdef ETH_ROW_PARAM_EN
    input  i_param_req, i_param_data,
    output o_param_rd, o_param_flag,
`endif
    input  i_pix_data, i_pix_valid, i_pix_sof, i_pix_eol, i_eth_busy,
    output o_raw_data, o_raw_data_valid, o_data_byte, o_row_number, o_sof,
    output o_overflow, o_drop_count
  );
endinterface

// File: rtl/eth_row_sender_row_buf_dp.sv
// Ping-pong line buffer: simple dual-port RAM, address MSB selects the bank, registered read.
module row_buf_dp #(
  parameter int ADDR_W = 11
) (
  input  logic            clk,
  input  logic            we,
  input  logic [ADDR_W:0] waddr,
  input  logic [7:0]      wdata,
  input  logic [ADDR_W:0] raddr,
  output logic [7:0]      q
);
  logic [7:0] mem [2**(ADDR_W+1)];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    q <= mem[raddr];
  end
endmodule

// File: rtl/eth_row_sender.sv
// Row-buffered feeder for the Ethernet TX chain: ping-pong capture plus start/replay FSM.
// Optional parameter frames are compiled in with `define ETH_ROW_PARAM_EN.
module eth_row_sender
  import eth_tx_pkg::*;
#(
  parameter int MAX_ROW_BYTES = 1440,
  parameter int ROW_ADDR_W    = 11,
  parameter int DATA_OFFSET   = 1,
  parameter int IFG_CYCLES    = 12
) (
  input logic             i_clk,
  input logic             i_rst_n,
  eth_row_sender_if.slave bus
);
  localparam int LEN_W = ROW_ADDR_W + 1;
  localparam int GAP_W = $clog2(IFG_CYCLES + 1);

  rd_state_t             state;
  logic                  wr_bank, rd_bank;
  logic [LEN_W-1:0]      wr_len;
  logic                  in_row, dropping, sof_seen;
  logic [7:0]            row_cnt;
  logic [1:0]            full, set_mask, clr_mask;
  row_desc_t             desc [2];
  logic                  overflow;
  logic [15:0]           drop_count;
  logic                  drop_now, we, store, drop_eol, row_sof;
  logic [7:0]            this_row;
  logic [ROW_ADDR_W-1:0] rd_ptr;
  logic [14:0]           pos, data_byte;
  logic [7:0]            row_number;
  logic                  sof_out, start_pulse, stream_en;
  logic [5:0]            wait_cnt;
  logic [GAP_W-1:0]      gap_cnt;
  logic [7:0]            rd_q;
  logic                  go_row, go_param, param_frame;

  row_buf_dp #(.ADDR_W(ROW_ADDR_W)) u_buf (
    .clk   (i_clk),
    .we    (we),
    .waddr ({wr_bank, wr_len[ROW_ADDR_W-1:0]}),
    .wdata (bus.i_pix_data),
    .raddr ({rd_bank, rd_ptr}),
    .q     (rd_q)
  );

  // The drop decision is taken on the first byte of a row and held until its eol.
  always_comb begin
    drop_now = in_row ? dropping : full[wr_bank];
    we       = bus.i_pix_valid && !drop_now && (wr_len < LEN_W'(MAX_ROW_BYTES));
    store    = bus.i_pix_valid && bus.i_pix_eol && !drop_now;
    drop_eol = bus.i_pix_valid && bus.i_pix_eol && drop_now;
    row_sof  = sof_seen || bus.i_pix_sof;
    this_row = row_sof ? '0 : row_cnt;
    set_mask = store ? (2'b01 << wr_bank) : '0;
    clr_mask = (state == DONE && !param_frame) ? (2'b01 << rd_bank) : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_bank    <= 1'b0;
      wr_len     <= '0;
      in_row     <= 1'b0;
      dropping   <= 1'b0;
      sof_seen   <= 1'b0;
      row_cnt    <= '0;
      full       <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
      for (int unsigned i = 0; i < 2; i++) desc[i] <= '0;
    end else begin
      overflow <= 1'b0;
      full     <= (full & ~clr_mask) | set_mask;
      if (bus.i_pix_valid) begin
        in_row   <= !bus.i_pix_eol;
        dropping <= drop_now && !bus.i_pix_eol;
        sof_seen <= row_sof && !bus.i_pix_eol;
        if (we) wr_len <= wr_len + LEN_W'(1);
        if (bus.i_pix_eol) begin
          row_cnt <= this_row + 8'd1;
          wr_len  <= '0;
        end
        if (store) begin
          desc[wr_bank] <= '{len: 15'(wr_len) + 15'(we), row: this_row, sof: row_sof};
          wr_bank       <= !wr_bank;
        end
        if (drop_eol) begin
          overflow <= 1'b1;
          if (drop_count != '1) drop_count <= drop_count + 16'd1;
        end
      end
    end
  end

  assign go_row = full[rd_bank] && !bus.i_eth_busy && (gap_cnt == '0);

  // The RAM address runs one cycle ahead of the byte shown, so rd_ptr advances on the edge
  // that opens each payload cycle (the IDLE->START edge itself when DATA_OFFSET is 0).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      rd_bank     <= 1'b0;
      rd_ptr      <= '0;
      pos         <= '0;
      wait_cnt    <= '0;
      gap_cnt     <= '0;
      start_pulse <= 1'b0;
      stream_en   <= 1'b0;
      data_byte   <= '0;
      row_number  <= '0;
      sof_out     <= 1'b0;
    end else begin
      start_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (go_param || go_row) begin
            state       <= START;
            start_pulse <= 1'b1;
            pos         <= '0;
            rd_ptr      <= '0;
            wait_cnt    <= 6'(DATA_OFFSET);
            if (go_param) begin
              data_byte  <= 15'(PARAM_FRAME_BYTES);
              row_number <= '0;
              sof_out    <= 1'b0;
            end else begin
              data_byte  <= desc[rd_bank].len;
              row_number <= desc[rd_bank].row;
              sof_out    <= desc[rd_bank].sof;
            end
            if (DATA_OFFSET == 0) begin
              stream_en <= 1'b1;
              rd_ptr    <= ROW_ADDR_W'(1);
              pos       <= 15'd1;
            end
          end
        end
        START, LEAD, STREAM: begin
          if (wait_cnt != '0) wait_cnt <= wait_cnt - 6'd1;
          if (wait_cnt > 6'd1) begin
            state <= LEAD;
          end else if (pos < data_byte) begin
            stream_en <= 1'b1;
            rd_ptr    <= rd_ptr + ROW_ADDR_W'(1);
            pos       <= pos + 15'd1;
            state     <= STREAM;
          end else begin
            stream_en <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          if (!param_frame) rd_bank <= !rd_bank;
          gap_cnt <= GAP_W'(IFG_CYCLES);
          state   <= GAP;
        end
        GAP: begin
          if (!bus.i_eth_busy) begin
            if (gap_cnt == '0) state <= IDLE;
            else gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ETH_ROW_PARAM_EN
  assign go_param = bus.i_param_req && !bus.i_eth_busy && (gap_cnt == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) param_frame <= 1'b0;
    else if (state == IDLE && (go_param || go_row)) param_frame <= go_param;
  end

  assign bus.o_param_flag = param_frame;
  assign bus.o_param_rd   = stream_en && param_frame;
  assign bus.o_raw_data   = !stream_en ? '0 : (param_frame ? bus.i_param_data : rd_q);
`else
  assign go_param       = 1'b0;
  assign param_frame    = 1'b0;
  assign bus.o_raw_data = stream_en ? rd_q : '0;
`endif

  assign bus.o_raw_data_valid = start_pulse;
  assign bus.o_data_byte      = data_byte;
  assign bus.o_row_number     = row_number;
  assign bus.o_sof            = sof_out;
  assign bus.o_overflow       = overflow;
  assign bus.o_drop_count     = drop_count;
endmodule

// File: tb/tb_eth_row_sender.sv
// Scoreboard bench for eth_row_sender: stimulus queues expected frames/bytes, a monitor checks them.
`timescale 1ns/1ps
module tb_eth_row_sender;
  typedef struct {
    int len;
    int row;
    bit sof;
    bit param;
  } frame_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #4 clk = ~clk;

  eth_row_sender_if bus();

  eth_row_sender #(
    .MAX_ROW_BYTES (1440),
    .ROW_ADDR_W    (11),
    .DATA_OFFSET   (1),
    .IFG_CYCLES    (12)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  frame_t     frame_q[$];
  logic [7:0] byte_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int starts = 0;
  int ovf_seen = 0;
  bit busy_auto = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic send_row(input int n, input bit sof, input int base, input int row,
                          input bit keep, input int gap);
    int kept;
    kept = (n > 1440) ? 1440 : n;
    if (keep) begin
      frame_q.push_back('{len: kept, row: row, sof: sof, param: 1'b0});
      for (int k = 0; k < kept; k++) byte_q.push_back(8'(base + k));
    end
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      bus.i_pix_valid = 1'b1;
      bus.i_pix_data  = 8'(base + k);
      bus.i_pix_sof   = sof && (k == 0);
      bus.i_pix_eol   = (k == n - 1);
    end
    @(posedge clk); #1;
    bus.i_pix_valid = 1'b0;
    bus.i_pix_sof   = 1'b0;
    bus.i_pix_eol   = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((frame_q.size() != 0 || byte_q.size() != 0 || bus.i_eth_busy) && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("drain_timeout", n < budget, 1);
    repeat (3) @(posedge clk);
  endtask

  task automatic wait_start(input int budget);
    int n;
    n = 0;
    while (!bus.o_raw_data_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("start_timeout", n < budget, 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, bus.o_raw_data_valid, 0);
    check({tag, "_raw"}, bus.o_raw_data, 0);
    check({tag, "_data_byte"}, bus.o_data_byte, 0);
    check({tag, "_row"}, bus.o_row_number, 0);
    check({tag, "_sof"}, bus.o_sof, 0);
    check({tag, "_overflow"}, bus.o_overflow, 0);
    check({tag, "_drop_count"}, bus.o_drop_count, 0);
  endtask

  // Monitor: pops the expected frame on each start pulse, then one expected byte per cycle.
  initial begin : monitor
    frame_t f;
    forever begin
      @(negedge clk);
      if (!rst_n) continue;
      if (bus.o_raw_data_valid) begin
        starts++;
        check("frame_expected", frame_q.size() != 0, 1);
        if (frame_q.size() != 0) begin
          f = frame_q.pop_front();
          check("data_byte", bus.o_data_byte, f.len);
          if (!f.param) begin
            check("row_number", bus.o_row_number, f.row);
            check("sof", bus.o_sof, f.sof);
          end
`ifdef ETH_ROW_PARAM_EN
          check("param_flag", bus.o_param_flag, f.param);
`endif
          if (busy_auto) check("ifg_respected", (cyc - fall_cyc) >= 12, 1);
          for (int k = 0; k < f.len; k++) begin
            @(negedge clk);
            if (!rst_n) break;
            check("byte_expected", byte_q.size() != 0, 1);
            if (byte_q.size() != 0) check("raw_data", bus.o_raw_data, byte_q.pop_front());
`ifdef ETH_ROW_PARAM_EN
            check("param_rd", bus.o_param_rd, f.param);
`endif
          end
        end
      end else begin
        check("raw_idle", bus.o_raw_data, 0);
      end
    end
  end

  initial begin : ovf_counter
    forever begin
      @(negedge clk);
      if (rst_n && bus.o_overflow) ovf_seen++;
    end
  end

  // Header stage model: goes busy 2 cycles after each start and stays busy for 200 cycles.
  initial begin : busy_model
    forever begin
      @(negedge clk);
      if (busy_auto && bus.o_raw_data_valid) begin
        repeat (2) @(posedge clk);
        #1 bus.i_eth_busy = 1'b1;
        repeat (200) @(posedge clk);
        #1 bus.i_eth_busy = 1'b0;
        fall_cyc = cyc;
      end
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin : stimulus
    int ovf0;
    int s0;
    bus.i_pix_data  = '0;
    bus.i_pix_valid = 1'b0;
    bus.i_pix_sof   = 1'b0;
    bus.i_pix_eol   = 1'b0;
    bus.i_eth_busy  = 1'b0;
`ifdef ETH_ROW_PARAM_EN
    bus.i_param_req  = 1'b0;
    bus.i_param_data = 8'h5A;
`endif
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_outputs_zero("reset");

    // Single 64-byte row with sof.
    send_row(64, 1'b1, 0, 0, 1'b1, 0);
    drain(2000);

    // Three 100-byte rows with the header stage going busy after each start.
    busy_auto = 1'b1;
    for (int r = 0; r < 3; r++) send_row(100, r == 0, 8'h40 * r, r, 1'b1, 4);
    drain(3000);
    busy_auto = 1'b0;

    // Busy held while four rows arrive: rows 2 and 3 are dropped.
    bus.i_eth_busy = 1'b1;
    ovf0 = ovf_seen;
    send_row(20, 1'b1, 8'h80, 0, 1'b1, 2);
    send_row(20, 1'b0, 8'h90, 1, 1'b1, 2);
    send_row(20, 1'b0, 8'hA0, 2, 1'b0, 2);
    send_row(20, 1'b0, 8'hB0, 3, 1'b0, 2);
    repeat (2) @(negedge clk);
    check("overflow_pulses", ovf_seen - ovf0, 2);
    check("drop_count", bus.o_drop_count, 2);
    @(posedge clk); #1 bus.i_eth_busy = 1'b0;
    drain(2000);
    send_row(20, 1'b0, 8'hC0, 4, 1'b1, 2);
    drain(2000);
    check("drop_count_hold", bus.o_drop_count, 2);

    // Oversized row is truncated to 1440 bytes.
    send_row(1500, 1'b1, 0, 0, 1'b1, 2);
    drain(5000);

    // 257 rows after one sof: the row number wraps back to 0 without sof.
    for (int r = 0; r < 257; r++) begin
      send_row(4, r == 0, r, r % 256, 1'b1, 0);
      drain(500);
    end

`ifdef ETH_ROW_PARAM_EN
    // Parameter request wins over a pending row.
    bus.i_eth_busy = 1'b1;
    send_row(10, 1'b1, 8'h20, 0, 1'b1, 2);
    frame_q.push_front('{len: 64, row: 0, sof: 1'b0, param: 1'b1});
    for (int k = 0; k < 64; k++) byte_q.push_front(8'h5A);
    @(posedge clk); #1;
    bus.i_param_req = 1'b1;
    bus.i_eth_busy  = 1'b0;
    wait_start(100);
    @(posedge clk); #1 bus.i_param_req = 1'b0;
    drain(1000);
`endif

    // Reset in the middle of a stream.
    send_row(64, 1'b1, 8'h33, 0, 1'b1, 0);
    wait_start(200);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk); #1;
    check_outputs_zero("midreset");
    frame_q.delete();
    byte_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    s0 = starts;
    repeat (100) @(posedge clk);
    check("no_frame_after_reset", starts - s0, 0);
    send_row(8, 1'b0, 8'h70, 0, 1'b1, 0);
    drain(500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
